bfly_out_buffer: RTL and testbench

// - Output-side reorder buffer of a single-path delay-feedback FFT stage; paired with the input delay line.
// - Per valid cycle, the radix-2 butterfly delivers a sum vector and a difference vector.
// - The block forwards each sum vector immediately and stores each difference vector.
// - After SIZE sums, it replays the stored differences back-to-back.
// - Result: one contiguous ordered stream of 2*SIZE vectors per block for the next stage.

---
 rtl/bfly_out_buffer.sv | 128 ++++++++++++
 tb/tb_bfly_out_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : bfly_out_buffer
// Description : Output reorder buffer of a single-path delay-feedback FFT
//               stage. Sum vectors are forwarded straight through while the
//               matching difference vectors are stored; once a half-block of
//               SIZE sums has passed, the stored differences are replayed
//               back-to-back, giving one ordered 2*SIZE-vector stream.
// Revision    : 1.0 - initial release
// ============================================================================
module bfly_out_buffer #(
   parameter int DATA_WIDTH = 10,
   parameter int SIZE       = 16,
   parameter int IN_SIZE    = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          bfly_valid,
   output logic                          bfly_ready,
   input  logic [DATA_WIDTH*IN_SIZE-1:0] sum_i,
   input  logic [DATA_WIDTH*IN_SIZE-1:0] sum_q,
   input  logic [DATA_WIDTH*IN_SIZE-1:0] diff_i,
   input  logic [DATA_WIDTH*IN_SIZE-1:0] diff_q,
   output logic                          dout_valid,
   output logic [DATA_WIDTH*IN_SIZE-1:0] dout_i,
   output logic [DATA_WIDTH*IN_SIZE-1:0] dout_q,
   output logic                          dout_last,
   output logic                          proto_err
);

   localparam int               C_VEC_W    = DATA_WIDTH * IN_SIZE;
   localparam int               C_CNT_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST_IDX = C_CNT_W'(SIZE - 1);

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [C_CNT_W-1:0]   r_wr_cnt;
   logic [C_CNT_W-1:0]   r_rd_cnt;
   logic [C_VEC_W-1:0]   r_mem_i [SIZE];
   logic [C_VEC_W-1:0]   r_mem_q [SIZE];
   logic                 w_accept;
   logic                 w_wr_last;
   logic                 w_rd_last;

   assign w_accept  = bfly_valid & bfly_ready;
   assign w_wr_last = (r_wr_cnt == C_LAST_IDX);
   assign w_rd_last = (r_rd_cnt == C_LAST_IDX);

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= FILL;
      else       r_state <= w_state_nxt;
   end

   // Next-state and ready: input side is open only while filling
   always_comb begin
      w_state_nxt = r_state;
      bfly_ready  = 1'b0;
      case (r_state)
         FILL: begin
            bfly_ready = 1'b1;
            if (bfly_valid && w_wr_last) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_rd_last) w_state_nxt = FILL;
         end
         default: w_state_nxt = FILL;
      endcase
   end

   // Write pointer advances per accepted vector, read pointer every drain cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
      end else begin
         if (w_accept)
            r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
         if (r_state == DRAIN)
            r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
      end
   end

   // Difference storage; contents are never reset since every slot is
   // rewritten before it is read in a block
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem_i[r_wr_cnt] <= diff_i;
         r_mem_q[r_wr_cnt] <= diff_q;
      end
   end

   // Output register: sums pass through in FILL, stored diffs replay in DRAIN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         dout_i     <= '0;
         dout_q     <= '0;
      end else if (w_accept) begin
         dout_valid <= 1'b1;
         dout_last  <= 1'b0;
         dout_i     <= sum_i;
         dout_q     <= sum_q;
      end else if (r_state == DRAIN) begin
         dout_valid <= 1'b1;
         dout_last  <= w_rd_last;
         dout_i     <= r_mem_i[r_rd_cnt];
         dout_q     <= r_mem_q[r_rd_cnt];
      end else begin
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
      end
   end

   // Sticky flag for an upstream that ignores ready
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                        proto_err <= 1'b0;
      else if (bfly_valid && !bfly_ready) proto_err <= 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_bfly_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bfly_out_buffer
// Description : Directed self-checking bench for bfly_out_buffer. Inputs are
//               changed on the falling edge; outputs are sampled on the
//               falling edge after the rising edge that produced them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bfly_out_buffer;

   localparam int DW = 10;
   localparam int SZ = 16;
   localparam int N  = 16;
   localparam int VW = DW * N;

   logic          clk;
   logic          rstn;
   logic          bfly_valid;
   logic          bfly_ready;
   logic [VW-1:0] sum_i, sum_q, diff_i, diff_q;
   logic          dout_valid;
   logic [VW-1:0] dout_i, dout_q;
   logic          dout_last;
   logic          proto_err;

   int checks = 0;
   int errors = 0;

   bfly_out_buffer #(.DATA_WIDTH(DW), .SIZE(SZ), .IN_SIZE(N)) dut (
      .clk(clk), .rstn(rstn),
      .bfly_valid(bfly_valid), .bfly_ready(bfly_ready),
      .sum_i(sum_i), .sum_q(sum_q), .diff_i(diff_i), .diff_q(diff_q),
      .dout_valid(dout_valid), .dout_i(dout_i), .dout_q(dout_q),
      .dout_last(dout_last), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector whose lane j holds (base + step*j), truncated to DW bits
   function automatic logic [VW-1:0] vec(input int base, input int step);
      logic [VW-1:0] v;
      int t;
      v = '0;
      for (int j = 0; j < N; j++) begin
         t = base + step * j;
         v[j*DW +: DW] = t[DW-1:0];
      end
      return v;
   endfunction

   // Apply one input cycle, then move to the falling edge after it is clocked
   task automatic drive(input logic v, input logic [VW-1:0] si, input logic [VW-1:0] sq,
                        input logic [VW-1:0] di, input logic [VW-1:0] dq);
      bfly_valid = v;
      sum_i = si; sum_q = sq; diff_i = di; diff_q = dq;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      drive(1'b0, '0, '0, '0, '0);
      drive(1'b0, '0, '0, '0, '0);
      checks++;
      if (dout_valid !== 1'b0 || dout_last !== 1'b0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got valid=%b last=%b err=%b, want 0 0 0", dout_valid, dout_last, proto_err);
      end
      checks++;
      if (dout_i !== '0 || dout_q !== '0) begin
         errors++;
         $display("FAIL reset_data: got i=%h q=%h, want 0", dout_i, dout_q);
      end
      checks++;
      if (bfly_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b, want 1", bfly_ready);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_no_gap();
      int low = 0;
      for (int k = 0; k < SZ; k++) begin
         drive(1'b1, vec(k, 1), vec(k + 300, 1), vec(100 + k, 1), vec(400 + k, 1));
         if (!bfly_ready) low++;
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(k, 1) || dout_q !== vec(k + 300, 1) || dout_last !== 1'b0) begin
            errors++;
            $display("FAIL t1_sum%0d: got v=%b l=%b i0=%0d, want v=1 l=0 i0=%0d", k, dout_valid, dout_last, $signed(dout_i[DW-1:0]), k);
         end
      end
      for (int k = 0; k < SZ; k++) begin
         drive(1'b0, '0, '0, '0, '0);
         if (!bfly_ready && k < SZ - 1) low++;
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(100 + k, 1) || dout_q !== vec(400 + k, 1) || dout_last !== (k == SZ - 1)) begin
            errors++;
            $display("FAIL t1_diff%0d: got v=%b l=%b i0=%0d, want v=1 l=%0d i0=%0d", k, dout_valid, dout_last, $signed(dout_i[DW-1:0]), (k == SZ - 1), 100 + k);
         end
      end
      checks++;
      if (low != SZ || bfly_ready !== 1'b1) begin
         errors++;
         $display("FAIL t1_ready_low: got %0d low cycles (ready now %b), want 16 (1)", low, bfly_ready);
      end
      drive(1'b0, '0, '0, '0, '0);
      checks++;
      if (dout_valid !== 1'b0 || dout_last !== 1'b0) begin
         errors++;
         $display("FAIL t1_idle: got v=%b l=%b, want 0 0", dout_valid, dout_last);
      end
   endtask

   task automatic test_gaps();
      for (int k = 0; k < SZ; k++) begin
         drive(1'b1, vec(k, 1), vec(k + 300, 1), vec(100 + k, 1), vec(400 + k, 1));
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(k, 1) || dout_q !== vec(k + 300, 1)) begin
            errors++;
            $display("FAIL t2_sum%0d: got v=%b i0=%0d, want v=1 i0=%0d", k, dout_valid, $signed(dout_i[DW-1:0]), k);
         end
         if (k < SZ - 1) begin
            drive(1'b0, vec(77, 1), vec(77, 1), vec(77, 1), vec(77, 1));
            checks++;
            if (dout_valid !== 1'b0 || dout_i !== vec(k, 1) || dout_q !== vec(k + 300, 1) || bfly_ready !== 1'b1) begin
               errors++;
               $display("FAIL t2_gap%0d: got v=%b rdy=%b i0=%0d, want v=0 rdy=1 held i0=%0d", k, dout_valid, bfly_ready, $signed(dout_i[DW-1:0]), k);
            end
         end
      end
      for (int k = 0; k < SZ; k++) begin
         drive(1'b0, '0, '0, '0, '0);
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(100 + k, 1) || dout_q !== vec(400 + k, 1) || dout_last !== (k == SZ - 1)) begin
            errors++;
            $display("FAIL t2_diff%0d: got v=%b l=%b i0=%0d, want v=1 i0=%0d", k, dout_valid, dout_last, $signed(dout_i[DW-1:0]), 100 + k);
         end
      end
      checks++;
      if (proto_err !== 1'b0) begin
         errors++;
         $display("FAIL t2_proto: got %b, want 0", proto_err);
      end
   endtask

   // Source is registered: it reacts to ready one clock after seeing it
   task automatic test_back_to_back();
      int gaps = 0;
      int w = 0;
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < SZ; k++) begin
            drive(1'b1, vec(50 * b + k, 1), vec(50 * b + k + 300, 1), vec(150 * b + 100 + k, 1), vec(150 * b + 400 + k, 1));
            if (b == 1 && k == 0) begin
               checks++;
               if (gaps != 1) begin
                  errors++;
                  $display("FAIL t3_gap: got %0d idle cycles, want 1", gaps);
               end
            end
            checks++;
            if (dout_valid !== 1'b1 || dout_i !== vec(50 * b + k, 1) || dout_q !== vec(50 * b + k + 300, 1)) begin
               errors++;
               $display("FAIL t3_b%0d_sum%0d: got v=%b i0=%0d, want v=1 i0=%0d", b, k, dout_valid, $signed(dout_i[DW-1:0]), 50 * b + k);
            end
         end
         for (int k = 0; k < SZ; k++) begin
            drive(1'b0, '0, '0, '0, '0);
            checks++;
            if (dout_valid !== 1'b1 || dout_i !== vec(150 * b + 100 + k, 1) || dout_q !== vec(150 * b + 400 + k, 1) || dout_last !== (k == SZ - 1)) begin
               errors++;
               $display("FAIL t3_b%0d_diff%0d: got v=%b i0=%0d, want v=1 i0=%0d", b, k, dout_valid, $signed(dout_i[DW-1:0]), 150 * b + 100 + k);
            end
         end
         if (b == 0) begin
            while (!bfly_ready && w < 8) begin
               drive(1'b0, '0, '0, '0, '0);
               if (!dout_valid) gaps++;
               w++;
            end
            checks++;
            if (!bfly_ready) begin
               errors++;
               $display("FAIL t3_ready_timeout: got ready=%b after %0d cycles, want 1", bfly_ready, w);
            end
            drive(1'b0, '0, '0, '0, '0);
            if (!dout_valid) gaps++;
         end
      end
   endtask

   task automatic test_proto();
      for (int k = 0; k < SZ; k++)
         drive(1'b1, vec(20 + k, 1), vec(320 + k, 1), vec(120 + k, 1), vec(420 + k, 1));
      for (int k = 0; k < SZ; k++) begin
         if (k == 4) drive(1'b1, vec(999, 1), vec(999, 1), vec(999, 1), vec(999, 1));
         else        drive(1'b0, '0, '0, '0, '0);
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(120 + k, 1) || dout_q !== vec(420 + k, 1) || dout_last !== (k == SZ - 1)) begin
            errors++;
            $display("FAIL t4_diff%0d: got v=%b i0=%0d, want v=1 i0=%0d", k, dout_valid, $signed(dout_i[DW-1:0]), 120 + k);
         end
         checks++;
         if (proto_err !== (k >= 4)) begin
            errors++;
            $display("FAIL t4_err%0d: got %b, want %0d", k, proto_err, (k >= 4));
         end
      end
      drive(1'b0, '0, '0, '0, '0);
      drive(1'b0, '0, '0, '0, '0);
      checks++;
      if (proto_err !== 1'b1 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL t4_sticky: got err=%b v=%b, want 1 0", proto_err, dout_valid);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < SZ; k++)
         drive(1'b1, vec(30 + k, 1), vec(330 + k, 1), vec(130 + k, 1), vec(430 + k, 1));
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, '0, '0, '0, '0);
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(130 + k, 1)) begin
            errors++;
            $display("FAIL t5_pre%0d: got v=%b i0=%0d, want v=1 i0=%0d", k, dout_valid, $signed(dout_i[DW-1:0]), 130 + k);
         end
      end
      rstn = 1'b0;
      #2;
      checks++;
      if (dout_valid !== 1'b0 || dout_last !== 1'b0 || dout_i !== '0 || dout_q !== '0 || bfly_ready !== 1'b1 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL t5_reset: got v=%b l=%b rdy=%b err=%b i=%h, want 0 0 1 0 0", dout_valid, dout_last, bfly_ready, proto_err, dout_i);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      for (int k = 0; k < SZ; k++) begin
         drive(1'b1, vec(60 + k, 1), vec(360 + k, 1), vec(160 + k, 1), vec(460 + k, 1));
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(60 + k, 1) || dout_q !== vec(360 + k, 1)) begin
            errors++;
            $display("FAIL t5_sum%0d: got v=%b i0=%0d, want v=1 i0=%0d", k, dout_valid, $signed(dout_i[DW-1:0]), 60 + k);
         end
      end
      for (int k = 0; k < SZ; k++) begin
         drive(1'b0, '0, '0, '0, '0);
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(160 + k, 1) || dout_q !== vec(460 + k, 1) || dout_last !== (k == SZ - 1)) begin
            errors++;
            $display("FAIL t5_diff%0d: got v=%b i0=%0d, want v=1 i0=%0d", k, dout_valid, $signed(dout_i[DW-1:0]), 160 + k);
         end
      end
   endtask

   task automatic test_lanes();
      for (int k = 0; k < SZ; k++) begin
         drive(1'b1, vec(-512, 1), vec(511, -1), vec(-512, 1), vec(-1, -1));
         checks++;
         if (dout_i !== vec(-512, 1) || dout_q !== vec(511, -1)) begin
            errors++;
            $display("FAIL t6_sum%0d: got i=%h q=%h, want i=%h q=%h", k, dout_i, dout_q, vec(-512, 1), vec(511, -1));
         end
      end
      for (int k = 0; k < SZ; k++) begin
         drive(1'b0, '0, '0, '0, '0);
         checks++;
         if (dout_valid !== 1'b1 || dout_i !== vec(-512, 1) || dout_q !== vec(-1, -1)) begin
            errors++;
            $display("FAIL t6_diff%0d: got i=%h q=%h, want i=%h q=%h", k, dout_i, dout_q, vec(-512, 1), vec(-1, -1));
         end
      end
   endtask

   initial begin
      rstn = 1'b0;
      bfly_valid = 1'b0;
      sum_i = '0; sum_q = '0; diff_i = '0; diff_q = '0;
      @(negedge clk);
      test_reset();
      test_no_gap();
      test_gaps();
      test_back_to_back();
      test_proto();
      test_reset_mid();
      test_lanes();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
